// File: rtl/bus_arbiter_pkg.sv
// Shared address map, arbiter state encoding and region lookup for the CPU/DMA bus arbiter.
package bus_arbiter_pkg;

  localparam logic [19:0] RAM_TOP   = 20'h20000;
  localparam logic [19:0] CHAR_BASE = 20'hB8000;
  localparam logic [19:0] CHAR_LAST = 20'hB8FFF;
  localparam logic [19:0] BIOS_BASE = 20'hFF000;

  typedef enum logic [1:0] {
    OWN_CPU = 2'd0,
    OWN_DMA = 2'd1,
    ACK     = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    REGION_NONE = 2'd0,
    REGION_DATA = 2'd1,
    REGION_CHAR = 2'd2,
    REGION_BIOS = 2'd3
  } region_t;

  // Char RAM wins over RAM, RAM wins over BIOS, so at most one region is ever hit.
  function automatic region_t region_of(input logic [19:0] a);
    if (a >= CHAR_BASE && a <= CHAR_LAST) return REGION_CHAR;
    if (a < RAM_TOP)                      return REGION_DATA;
    if (a >= BIOS_BASE)                   return REGION_BIOS;
    return REGION_NONE;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// CPU, DMA and memory-side signals of the shared bus.
// slave = arbiter view; master = the CPU/DMA/memory environment around it.
interface bus_arbiter_if;

  logic [19:0] cpu_address;
  logic [7:0]  cpu_out;
  logic        cpu_we;
  logic [7:0]  cpu_in;
  logic        cpu_ce;

  logic        dma_req;
  logic [19:0] dma_address;
  logic [7:0]  dma_d;
  logic        dma_we;
  logic [7:0]  dma_q;
  logic        dma_ack;

  logic [19:0] mem_address;
  logic [7:0]  mem_d;
  logic        w_data;
  logic        w_char;
  logic        w_bios;
  logic [7:0]  in_data;
  logic [7:0]  in_char;
  logic [7:0]  in_bios;

  modport slave (
    input  cpu_address, cpu_out, cpu_we,
    input  dma_req, dma_address, dma_d, dma_we,
    input  in_data, in_char, in_bios,
    output cpu_in, cpu_ce, dma_q, dma_ack,
    output mem_address, mem_d, w_data, w_char, w_bios
  );

  modport master (
    output cpu_address, cpu_out, cpu_we,
    output dma_req, dma_address, dma_d, dma_we,
    output in_data, in_char, in_bios,
    input  cpu_in, cpu_ce, dma_q, dma_ack,
    input  mem_address, mem_d, w_data, w_char, w_bios
  );

endinterface

// File: rtl/bus_arbiter_decode.sv
// Combinational region decode and read-data mux for the CPU-side memory map.
// Also reused by the top-level glue, so it has no clock or owner knowledge.
module bus_decode
  import bus_arbiter_pkg::*;
(
  input  logic [19:0] address,
  input  logic [7:0]  in_data,
  input  logic [7:0]  in_char,
  input  logic [7:0]  in_bios,
  output logic        sel_data,
  output logic        sel_char,
  output logic        sel_bios,
  output logic [7:0]  rd_data
);

  region_t region;

  assign region   = region_of(address);
  assign sel_data = (region == REGION_DATA);
  assign sel_char = (region == REGION_CHAR);
  assign sel_bios = (region == REGION_BIOS);

  // Unmapped space reads as an open bus.
  always_comb begin
    rd_data = 8'hFF;
    case (region)
      REGION_DATA: rd_data = in_data;
      REGION_CHAR: rd_data = in_char;
      REGION_BIOS: rd_data = in_bios;
      default:     rd_data = 8'hFF;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares the CPU memory bus with one DMA requester, stalling the CPU via cpu_ce for each DMA access.
//   state   | meaning
//   OWN_CPU | CPU owns the bus; grant DMA when requested and the gap counter is spent
//   OWN_DMA | single DMA access, CPU stalled; read data captured at the end of the cycle
//   ACK     | dma_ack high, CPU runs; gap counter reloaded to enforce CPU slots
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned CPU_SLOTS = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  bus_arbiter_if.slave bus
);

  localparam logic [3:0] GAP_RELOAD = (CPU_SLOTS >= 1) ? 4'(CPU_SLOTS - 1) : 4'd0;
  localparam logic       BACK_TO_BACK = (CPU_SLOTS == 0);

  arb_state_t state, state_nxt;
  logic [3:0] gap, gap_nxt;
  logic       dma_owns;
  logic       cpu_ce_raw;
  logic       dma_ack_r;
  logic [7:0] dma_q_r;

  logic       owner_we;
  logic       sel_data, sel_char, sel_bios;
  logic [7:0] rd_data;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= OWN_CPU;
      gap       <= 4'd0;
      dma_ack_r <= 1'b0;
      dma_q_r   <= 8'h00;
    end else begin
      state     <= state_nxt;
      gap       <= gap_nxt;
      dma_ack_r <= (state == OWN_DMA);
      if (state == OWN_DMA) dma_q_r <= rd_data;
    end
  end

  always_comb begin
    state_nxt  = state;
    gap_nxt    = gap;
    dma_owns   = 1'b0;
    cpu_ce_raw = 1'b1;
    case (state)
      OWN_CPU: begin
        if (gap != 4'd0)  gap_nxt   = gap - 4'd1;
        else if (bus.dma_req) state_nxt = OWN_DMA;
      end
      OWN_DMA: begin
        dma_owns   = 1'b1;
        cpu_ce_raw = 1'b0;
        state_nxt  = ACK;
      end
      ACK: begin
        // The DMA is still stepping off the ack here, so its request is only
        // honoured immediately when no CPU slots are reserved.
        gap_nxt   = GAP_RELOAD;
        state_nxt = (BACK_TO_BACK && bus.dma_req) ? OWN_DMA : OWN_CPU;
      end
      default: begin
        state_nxt = OWN_CPU;
        gap_nxt   = 4'd0;
      end
    endcase
  end

  assign bus.mem_address = dma_owns ? bus.dma_address : bus.cpu_address;
  assign bus.mem_d       = dma_owns ? bus.dma_d       : bus.cpu_out;
  assign owner_we        = dma_owns ? bus.dma_we      : bus.cpu_we;

  bus_decode u_decode (
    .address  (bus.mem_address),
    .in_data  (bus.in_data),
    .in_char  (bus.in_char),
    .in_bios  (bus.in_bios),
    .sel_data (sel_data),
    .sel_char (sel_char),
    .sel_bios (sel_bios),
    .rd_data  (rd_data)
  );

  assign bus.w_data  = owner_we & sel_data & reset_n;
  assign bus.w_char  = owner_we & sel_char & reset_n;
  assign bus.w_bios  = owner_we & sel_bios & reset_n;
  assign bus.cpu_in  = rd_data;
  assign bus.cpu_ce  = cpu_ce_raw & reset_n;
  assign bus.dma_q   = dma_q_r;
  assign bus.dma_ack = dma_ack_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, decode, DMA read/write, fairness at two slot
// settings, and reset during a DMA access.
module tb_bus_arbiter;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  bus_arbiter_if b0 ();
  bus_arbiter_if b1 ();

  bus_arbiter #(.CPU_SLOTS(1)) dut0 (.clock(clock), .reset_n(reset_n), .bus(b0.slave));
  bus_arbiter #(.CPU_SLOTS(3)) dut1 (.clock(clock), .reset_n(reset_n), .bus(b1.slave));

  always #5 clock = ~clock;

  // Memory models: only 20'h00100 holds A7 in RAM, so dma_q proves the DMA address was used.
  assign b0.in_data = (b0.mem_address == 20'h00100) ? 8'hA7 : 8'h11;
  assign b0.in_char = 8'h22;
  assign b0.in_bios = 8'h33;
  assign b1.in_data = 8'h44;
  assign b1.in_char = 8'h55;
  assign b1.in_bios = 8'h66;

  task automatic next;
    @(posedge clock);
    #1;
  endtask

  task automatic look;
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] pat;
  int acks, ce_cnt, run, max_run;

  initial begin
    b0.cpu_address = 20'h00010; b0.cpu_out = 8'h00; b0.cpu_we = 1'b1;
    b0.dma_req = 1'b0; b0.dma_address = 20'h0; b0.dma_d = 8'h00; b0.dma_we = 1'b0;
    b1.cpu_address = 20'h00000; b1.cpu_out = 8'h00; b1.cpu_we = 1'b0;
    b1.dma_req = 1'b0; b1.dma_address = 20'h00040; b1.dma_d = 8'h00; b1.dma_we = 1'b0;

    // Reset held three cycles with a CPU write pending
    reset_n = 1'b0;
    repeat (3) next;
    look;
    check("rst_cpu_ce",  b0.cpu_ce,  1'b0);
    check("rst_w_data",  b0.w_data,  1'b0);
    check("rst_dma_ack", b0.dma_ack, 1'b0);
    check("rst_dma_q",   b0.dma_q,   8'h00);
    next; reset_n = 1'b1;
    look;
    check("rel_cpu_ce", b0.cpu_ce, 1'b1);
    check("rel_w_data", b0.w_data, 1'b1);

    // CPU-only decode
    next; b0.cpu_address = 20'hB8000; b0.cpu_out = 8'h5A; b0.cpu_we = 1'b1;
    look;
    check("char_we",  {b0.w_data, b0.w_char, b0.w_bios}, 3'b010);
    check("char_d",   b0.mem_d, 8'h5A);
    next; b0.cpu_address = 20'h1FFFF; b0.cpu_we = 1'b0;
    look;
    check("rd_ram_top", b0.cpu_in, 8'h11);
    next; b0.cpu_address = 20'h30000; b0.cpu_we = 1'b1;
    look;
    check("hole_rd", b0.cpu_in, 8'hFF);
    check("hole_we", {b0.w_data, b0.w_char, b0.w_bios}, 3'b000);
    next; b0.cpu_address = 20'hFFFFF; b0.cpu_we = 1'b0;
    look;
    check("rd_bios_top", b0.cpu_in, 8'h33);
    next; b0.cpu_address = 20'h20000; b0.cpu_we = 1'b1;
    look;
    check("ram_end_rd", b0.cpu_in, 8'hFF);
    check("ram_end_we", {b0.w_data, b0.w_char, b0.w_bios}, 3'b000);
    next; b0.cpu_address = 20'h00050; b0.cpu_we = 1'b0;

    // Request withdrawn before any edge samples it
    b0.dma_req = 1'b1; #2; b0.dma_req = 1'b0;
    next;
    look;
    check("nogrant_ce",  b0.cpu_ce,  1'b1);
    check("nogrant_ack", b0.dma_ack, 1'b0);

    // Single DMA read
    next; b0.dma_req = 1'b1; b0.dma_address = 20'h00100; b0.dma_we = 1'b0;
    look;
    check("dmard_req_ce", b0.cpu_ce, 1'b1);
    next;
    look;
    check("dmard_stall",  b0.cpu_ce,      1'b0);
    check("dmard_addr",   b0.mem_address, 20'h00100);
    check("dmard_noack",  b0.dma_ack,     1'b0);
    next; b0.dma_req = 1'b0;
    look;
    check("dmard_ack",    b0.dma_ack, 1'b1);
    check("dmard_q",      b0.dma_q,   8'hA7);
    check("dmard_ack_ce", b0.cpu_ce,  1'b1);
    next;
    look;
    check("dmard_ack_drop", b0.dma_ack, 1'b0);

    // DMA write collides with a CPU write presented during the stall
    next; b0.dma_req = 1'b1; b0.dma_address = 20'h00300; b0.dma_d = 8'h33; b0.dma_we = 1'b1;
    look;
    next; b0.cpu_address = 20'h00200; b0.cpu_out = 8'hC3; b0.cpu_we = 1'b1;
    look;
    check("col_stall", b0.cpu_ce,      1'b0);
    check("col_daddr", b0.mem_address, 20'h00300);
    check("col_dd",    b0.mem_d,       8'h33);
    check("col_dwe",   b0.w_data,      1'b1);
    next; b0.dma_req = 1'b0;
    look;
    check("col_ack",   b0.dma_ack,     1'b1);
    check("col_ce",    b0.cpu_ce,      1'b1);
    check("col_caddr", b0.mem_address, 20'h00200);
    check("col_cd",    b0.mem_d,       8'hC3);
    check("col_cwe",   b0.w_data,      1'b1);
    next; b0.cpu_we = 1'b0; b0.dma_we = 1'b0;
    look;
    next;

    // Fairness, CPU_SLOTS=1: CPU, then DMA/ACK/CPU repeating
    b0.dma_req = 1'b1;
    pat = '0; acks = 0; ce_cnt = 0; run = 0; max_run = 0;
    for (int i = 0; i < 30; i++) begin
      look;
      pat = {pat[30:0], b0.cpu_ce};
      acks += int'(b0.dma_ack);
      ce_cnt += int'(b0.cpu_ce);
      run = b0.cpu_ce ? 0 : run + 1;
      if (run > max_run) max_run = run;
      next;
    end
    b0.dma_req = 1'b0;
    check("fair1_acks", acks,    32'd10);
    check("fair1_ce",   ce_cnt,  32'd20);
    check("fair1_pat",  pat,     32'b00_1_011_011_011_011_011_011_011_011_011_01);
    check("fair1_run",  max_run, 32'd1);

    // Fairness, CPU_SLOTS=3: one stall then ACK plus three CPU cycles
    b1.dma_req = 1'b1;
    pat = '0; acks = 0; ce_cnt = 0; run = 0; max_run = 0;
    for (int i = 0; i < 30; i++) begin
      look;
      pat = {pat[30:0], b1.cpu_ce};
      acks += int'(b1.dma_ack);
      ce_cnt += int'(b1.cpu_ce);
      run = b1.cpu_ce ? 0 : run + 1;
      if (run > max_run) max_run = run;
      next;
    end
    b1.dma_req = 1'b0;
    check("fair3_acks", acks,    32'd6);
    check("fair3_ce",   ce_cnt,  32'd24);
    check("fair3_pat",  pat,     32'b00_1_01111_01111_01111_01111_01111_0111);
    check("fair3_run",  max_run, 32'd1);

    // Reset lands while the DMA owns the bus
    b0.dma_req = 1'b1; b0.dma_address = 20'h00100; b0.dma_we = 1'b0;
    look;
    check("mid_req_ce", b0.cpu_ce, 1'b1);
    next;
    look;
    check("mid_stall", b0.cpu_ce, 1'b0);
    reset_n = 1'b0;
    next; b0.dma_req = 1'b0;
    look;
    check("mid_rst_ack", b0.dma_ack, 1'b0);
    check("mid_rst_q",   b0.dma_q,   8'h00);
    check("mid_rst_ce",  b0.cpu_ce,  1'b0);
    next; reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      look;
      check("mid_after_ack", b0.dma_ack, 1'b0);
      check("mid_after_ce",  b0.cpu_ce,  1'b1);
      next;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single CPU-side memory bus (128K RAM, 4K char RAM, 4K BIOS) between the `cpu` core and one DMA requester, such as a future SD-card or PS/2 buffer engine.
- Performs the region decode and read-data mux that currently sit in top-level glue.
- Stalls the CPU through its `ce` input while the DMA owns the bus.
- Sits between `cpu` and the memories (`base`, `char` port 0, `bios`) at the top level.
- Memories return `q` within the same bus cycle because their clock is faster than `clock`.

Parameters:
- RAM_TOP, 20'h20000: RAM selected when address < RAM_TOP.
- CHAR_BASE, 20'hB8000: first char RAM address.
- CHAR_LAST, 20'hB8FFF: last char RAM address (inclusive).
- BIOS_BASE, 20'hFF000: BIOS selected when address >= BIOS_BASE.
- CPU_SLOTS, 1: minimum CPU-owned cycles after each DMA ACK cycle before the next DMA access (range 0..15).

Ports:
- clock  in  1  bus clock (clock_25)
- reset_n  in  1  synchronous, active-low reset
- cpu_address  in  20  CPU address
- cpu_out  in  8  CPU write data
- cpu_we  in  1  CPU write strobe
- cpu_in  out  8  read data to CPU
- cpu_ce  out  1  CPU clock enable; 0 = stalled
- dma_req  in  1  DMA access request; held until dma_ack
- dma_address  in  20  DMA address; stable while dma_req=1
- dma_d  in  8  DMA write data
- dma_we  in  1  DMA write (1) / read (0)
- dma_q  out  8  registered DMA read data
- dma_ack  out  1  one-cycle completion pulse
- mem_address  out  20  muxed address to memories
- mem_d  out  8  muxed write data
- w_data  out  1  RAM write enable
- w_char  out  1  char RAM write enable
- w_bios  out  1  BIOS write enable
- in_data  in  8  RAM read data
- in_char  in  8  char RAM read data
- in_bios  in  8  BIOS read data

Behaviour:
- Clocking and reset
  - One clock; reset is synchronous, active-low.
  - While reset_n=0 at a rising edge: state <= OWN_CPU, gap counter <= 0, dma_ack <= 0, dma_q <= 8'h00.
  - While reset_n=0: cpu_ce=0 and w_data/w_char/w_bios=0, combinationally gated by reset_n.
- Decode, applied to mem_address
  - sel_char = CHAR_BASE <= a <= CHAR_LAST.
  - sel_data = a < RAM_TOP.
  - sel_bios = a >= BIOS_BASE.
  - Priority is char > data > bios.
  - Read mux returns in_char / in_data / in_bios by that priority; 8'hFF when nothing is selected.
  - w_x = owner_we & sel_x & reset_n. Only the highest-priority selected region is written.
- Owner mux (combinational)
  - In state OWN_DMA: mem_address/mem_d/we come from the DMA.
  - In all other states: they come from the CPU.
  - cpu_in always equals the read mux output.
- FSM states
  - OWN_CPU: cpu_ce=1.
    - If dma_req=1 and gap=0: next state OWN_DMA.
    - If gap!=0: gap <= gap-1.
  - OWN_DMA: cpu_ce=0, CPU writes blocked; exactly one DMA access.
    - At end of cycle: dma_q <= read mux output (also on DMA writes, value don't-care), dma_ack <= 1, next state ACK.
  - ACK: dma_ack=1, cpu_ce=1, CPU owns the bus.
    - dma_req is ignored this cycle, because the DMA is advancing.
    - gap <= CPU_SLOTS-1 when CPU_SLOTS>=1, else 0.
    - Next state: OWN_DMA if CPU_SLOTS=0 and dma_req=1; otherwise OWN_CPU.
  - dma_ack is low in every state except ACK.
- Timing and guarantees
  - DMA latency from dma_req rising (sampled in OWN_CPU with gap=0) to dma_ack: 2 cycles.
  - With CPU_SLOTS=1 and dma_req held high continuously, the pattern repeats OWN_DMA, ACK, OWN_CPU. The CPU gets 2 of every 3 cycles.
  - The CPU is never stalled for more than one consecutive cycle.
- Boundary cases
  - dma_req dropped before being granted: no access, no ack.
  - dma_req dropped during OWN_DMA: the access still completes and is acked; the DMA must not do this.
  - Reset asserted during OWN_DMA or ACK: the pending transfer is abandoned, and dma_ack is 0 in the cycle after reset.
  - Address 20'hFFFFF selects BIOS. 20'h1FFFF selects RAM. 20'h20000 selects nothing (reads 8'hFF, writes dropped).

Decomposition:
- Shared package holds the address map constants (RAM_TOP, CHAR_BASE, CHAR_LAST, BIOS_BASE) and the 2-bit state encoding (OWN_CPU=0, OWN_DMA=1, ACK=2).
- One sub-module, `bus_decode`: purely combinational; address in, sel_data/sel_char/sel_bios out, plus the read mux. The top-level de0 glue reuses it once this block replaces that glue.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with cpu_we=1 and cpu_address=20'h00010. Required: cpu_ce=0, w_data=0, dma_ack=0, dma_q=8'h00; after release, cpu_ce=1 on the first cycle.
- CPU-only decode:
  - Writing 8'h5A to 20'hB8000 raises w_char only.
  - Reading 20'h1FFFF returns in_data.
  - Reading 20'h30000 returns 8'hFF, and no write enable fires for a write there.
- Single DMA read: in_data=8'hA7 at 20'h00100; pulse dma_req with dma_we=0. Required: cpu_ce=0 for exactly one cycle, mem_address=20'h00100 in that cycle, and the next cycle has dma_ack=1 and dma_q=8'hA7.
- DMA write collision: CPU writes 20'h00200 while DMA writes 8'h33 to 20'h00300. Required: in the OWN_DMA cycle only the DMA write happens (mem_address=20'h00300, mem_d=8'h33); the CPU write occurs in the following cycle, when cpu_ce=1.
- Fairness: dma_req held high for 30 cycles with CPU_SLOTS=1, then with CPU_SLOTS=3. Required: 10 acks and 20 cycles with cpu_ce=1 in the first run; in the second, the pattern is 1 stall then 3 CPU cycles.
- Reset mid-transfer: assert reset_n=0 during OWN_DMA. Required: no dma_ack ever pulses for that transfer, and the state returns to OWN_CPU.
